conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming 5x5 sliding-window generator; sits directly upstream of conv_layer.
- Accepts one signed pixel per cycle in raster order, for a 28x28 frame.
- Presents the full 25-pixel window, one window per accepted pixel, once the window lies fully inside the frame.
- Produces the 24x24 = 576 windows per frame that conv_layer consumes. There is no backpressure, because conv_layer has no stall input.

Parameters:
- DATA_W, 32, pixel width in bits (two's complement).
- IMG_W, 28, frame width in pixels.
- IMG_H, 28, frame height in pixels.
- K, 5, window edge length.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_data is a valid pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid; marks the pixel as (row 0, col 0).
- in_data  in  DATA_W  pixel, signed.
- out_valid  out  1  out_window holds a complete in-frame window.
- out_last  out  1  with out_valid: last window of the frame.
- out_window  out  K*K*DATA_W  window; element (r,c) occupies bits [(r*K+c)*DATA_W +: DATA_W] and maps to conv_layer data_rc.
  - r=0 is the oldest (top) row; c=0 is the oldest (left) column.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_last=0, out_window=0.
  - row/col counters and window registers cleared to 0.
  - Line-buffer storage is not reset; its contents are don't-care because output is gated by the counters.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1; they advance only on in_valid.
  - col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0.
- in_sof with in_valid: the pixel is taken as (0,0) regardless of the counters, so a mid-frame restart is allowed. Counters then continue from (0,1).
- Line buffers: K-1 = 4 row delays, each IMG_W deep.
  - On an accepted pixel, the column vector (top to bottom) is {lb3_out, lb2_out, lb1_out, lb0_out, in_data}, i.e. the pixel at (row-4 .. row, col).
  - Read-before-write at address col. lb0 takes in_data; lb(i+1) takes lb(i)_out.
- Window shift, on an accepted pixel: window[r][c] <= window[r][c+1] for c<K-1; window[r][K-1] <= column vector[r].
- Output qualification, registered:
  - out_valid <= in_valid and (row >= K-1) and (col >= K-1), using the row/col of the accepted pixel.
  - out_last <= the same condition and row==IMG_H-1 and col==IMG_W-1.
- Latency: the window containing pixel (row,col) as element (K-1,K-1) is on out_window in the cycle after that pixel is accepted.
- Idle (in_valid=0): out_valid=0, out_last=0; window, counters and buffers hold.
- Windows never span a row wrap: col < K-1 forces out_valid=0.
- Data passes through bit-exact; no arithmetic or sign change.
- Frames may be back-to-back with no gap cycles.
- Output count: exactly (IMG_H-K+1)*(IMG_W-K+1) out_valid cycles per complete frame.

Decomposition:
- Shared package cnn_pkg holds DATA_W=32, IMG_W=28, IMG_H=28, K=5, CONV_W=IMG_W-K+1, CONV_H=IMG_H-K+1, and the window-index helper (r*K+c).
- One sub-module: cnn_line_buffer, a single-row delay of depth IMG_W and width DATA_W with enable, instantiated K-1 times.

Test Plan:
- Ramp frame, pixel = row*28+col, continuous in_valid, in_sof on the first pixel:
  - First out_valid occurs the cycle after pixel 116; window data_00=0, data_04=4, data_40=112, data_44=116.
  - Exactly 576 out_valid pulses.
- Same ramp, last window: out_last with out_valid exactly once; data_00=667 and data_44=783.
- Ramp with random in_valid gaps, 30% idle: window sequence identical to the continuous run; out_valid never asserted on an idle cycle.
- Negative pixels (0x80000000, 0xFFFFFFFF) at known positions: they appear unchanged in the expected window slots.
- in_sof asserted at pixel index 300 of frame 1, then a full ramp: output matches a clean frame starting at that point; the first valid window appears after pixel (4,4) of the new frame.
- rst_n pulsed low mid-frame: outputs go to 0 asynchronously. The next frame, started with in_sof, produces 576 correct windows.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants and the window element index helper.
package cnn_pkg;

    localparam int DATA_W = 32;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    localparam int CONV_W = IMG_W - K + 1;
    localparam int CONV_H = IMG_H - K + 1;

    // Flat element index of window position (r,c); r=0 top row, c=0 left column.
    function automatic int win_idx(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One-row pixel delay: returns the pixel stored at addr_i one frame row ago,
// then overwrites that slot with din_i when enabled (read-before-write).
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int DW    = DATA_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    // Deliberately unreset: stale contents are masked by the row counter upstream.
    logic [DW-1:0] mem_q [DEPTH];

    assign dout_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator over a raster-order frame; one
// registered window per accepted pixel once the window lies inside the frame.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int K      = cnn_pkg::K
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [K*K*DATA_W-1:0]   out_window
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_ok, last_ok;
    logic          out_valid_q, out_last_q;

    logic [K-2:0][DATA_W-1:0]        lb_in, lb_out;
    logic [K-1:0][DATA_W-1:0]        col_vec;
    logic [K-1:0][K-1:0][DATA_W-1:0] win_q, win_d;

    // A start-of-frame pixel is (0,0) whatever the counters say.
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = cur_col + 1'b1;
        row_d   = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end
    end

    assign win_ok  = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
    assign last_ok = win_ok && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

    // Line buffers cascade: lb0 holds the previous row, lb(K-2) the oldest.
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        if (g == 0) begin : g_first
            assign lb_in[g] = in_data;
        end else begin : g_chain
            assign lb_in[g] = lb_out[g-1];
        end

        cnn_line_buffer #(
            .DEPTH (IMG_W),
            .DW    (DATA_W),
            .AW    (CW)
        ) u_lb (
            .clk    (clk),
            .en_i   (in_valid),
            .addr_i (cur_col),
            .din_i  (lb_in[g]),
            .dout_o (lb_out[g])
        );

        assign col_vec[K-2-g] = lb_out[g];
    end

    assign col_vec[K-1] = in_data;

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = col_vec[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid && win_ok;
            out_last_q  <= in_valid && last_ok;
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    for (genvar r = 0; r < K; r++) begin : g_or
        for (genvar c = 0; c < K; c++) begin : g_oc
            assign out_window[win_idx(r, c)*DATA_W +: DATA_W] = win_q[r][c];
        end
    end

endmodule
